// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Smallest divisor that still yields a high and a low phase.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus registered waveform/tick generation for one divisor.
// The divisor is captured on load, so the boundary flag never depends on
// the divisor being loaded in the same cycle.
module clk_div_core #(
  parameter int DW      = 8,
  parameter int DEF_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] div,
  output logic          clk_out,
  output logic          tick,
  output logic          last
);

  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_n;
  logic [DW-1:0] div_r;
  logic [DW-1:0] div_n;
  logic          run;
  logic [DW:0]   hi;

  // Boundary is the last low cycle of the period in effect.
  assign last = run && (cnt == div_r - 1'b1);

  // Next count and high-phase length; hi is one bit wider so N=2^DW-1 works.
  always_comb begin
    div_n = load ? div : div_r;
    hi    = ({1'b0, div_n} + {{DW{1'b0}}, 1'b1}) >> 1;
    if (!en || load || last) cnt_n = '0;
    else                     cnt_n = cnt + 1'b1;
  end

  // Counter, captured divisor and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      div_r   <= DW'(DEF_DIV);
      run     <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      div_r   <= div_n;
      run     <= en;
      clk_out <= en && ({1'b0, cnt_n} < hi);
      tick    <= en && (cnt_n == '0);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: config handshake and boundary sequencing FSM
// in front of the counter/waveform core.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DW      = 8,
  parameter int DEF_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_div,
  input  logic          cfg_en,
  output logic          cfg_err,
  output logic          clk_out,
  output logic          tick,
  output logic [DW-1:0] cur_div,
  output logic [1:0]    state
);

  state_t        st, st_n;
  logic [DW-1:0] div_n;
  logic [DW-1:0] pend_div, pend_div_n;
  logic          pend_en, pend_en_n;
  logic          err_n;
  logic          core_en, load, last;
  logic          acc, bad;
  logic          app, app_en;
  logic [DW-1:0] app_div;

  assign state     = st;
  assign cfg_ready = (st != PEND);
  assign acc       = cfg_valid && cfg_ready;
  // A stop request never errors; its divisor field is ignored.
  assign bad       = cfg_en && (cfg_div < DW'(MIN_DIV));

  // Next state: changes land only on the boundary, else they wait in PEND.
  always_comb begin
    st_n       = st;
    div_n      = cur_div;
    pend_div_n = pend_div;
    pend_en_n  = pend_en;
    err_n      = acc && bad;
    load       = 1'b0;
    app        = 1'b0;
    app_en     = 1'b0;
    app_div    = cur_div;
    case (st)
      IDLE: if (acc && !bad && cfg_en) begin
        app     = 1'b1;
        app_en  = 1'b1;
        app_div = cfg_div;
      end
      RUN: if (acc && !bad) begin
        if (last) begin
          app     = 1'b1;
          app_en  = cfg_en;
          app_div = cfg_div;
        end else begin
          st_n       = PEND;
          pend_div_n = cfg_div;
          pend_en_n  = cfg_en;
        end
      end
      PEND: if (last) begin
        app        = 1'b1;
        app_en     = pend_en;
        app_div    = pend_div;
        pend_div_n = '0;
        pend_en_n  = 1'b0;
      end
      default: st_n = IDLE;
    endcase
    if (app) begin
      if (app_en) begin
        st_n  = RUN;
        div_n = app_div;
        load  = 1'b1;
      end else begin
        st_n  = IDLE;
      end
    end
    core_en = (st_n != IDLE);
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      cur_div  <= DW'(DEF_DIV);
      pend_div <= '0;
      pend_en  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      st       <= st_n;
      cur_div  <= div_n;
      pend_div <= pend_div_n;
      pend_en  <= pend_en_n;
      cfg_err  <= err_n;
    end
  end

  clk_div_core #(.DW(DW), .DEF_DIV(DEF_DIV)) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (core_en),
    .load    (load),
    .div     (div_n),
    .clk_out (clk_out),
    .tick    (tick),
    .last    (last)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench: stimulus pushes hand-computed per-cycle expectations,
// a monitor on the falling edge pops and compares them.
module tb_clk_div_ctrl;

  localparam logic [1:0] S_I = 2'd0, S_R = 2'd1, S_P = 2'd2;

  typedef struct {
    logic       co;
    logic       tk;
    logic [1:0] st;
    logic       rdy;
    logic       err;
    logic [7:0] cd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_div = '0;
  logic       cfg_en = 1'b0;
  logic       cfg_err, clk_out, tick;
  logic [7:0] cur_div;
  logic [1:0] state;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(.DW(8), .DEF_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .cur_div   (cur_div),
    .state     (state)
  );

  // Monitor: every cycle is an output cycle; compare against queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (clk_out !== e.co || tick !== e.tk || state !== e.st ||
          cfg_ready !== e.rdy || cfg_err !== e.err || cur_div !== e.cd) begin
        bad++;
        $display("FAIL cycle%0d: got clk_out=%b tick=%b state=%0d ready=%b err=%b cur_div=%0d, want %b %b %0d %b %b %0d",
                 cyc_no, clk_out, tick, state, cfg_ready, cfg_err, cur_div,
                 e.co, e.tk, e.st, e.rdy, e.err, e.cd);
      end
      cyc_no++;
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic en,
                     input logic co, input logic tk, input logic [1:0] st,
                     input logic rdy, input logic err, input logic [7:0] cd);
    exp_t e;
    cfg_valid = v;
    cfg_div   = d;
    cfg_en    = en;
    e.co = co; e.tk = tk; e.st = st; e.rdy = rdy; e.err = err; e.cd = cd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic run(input string co, input string tk, input logic [1:0] st,
                     input logic rdy, input logic [7:0] cd);
    for (int i = 0; i < co.len(); i++)
      cyc(1'b0, 8'd0, 1'b0, co[i] == "1", tk[i] == "1", st, rdy, 1'b0, cd);
  endtask

  initial begin
    // reset and idle
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, S_I, 1, 0, 2);
    cyc(0, 0, 0, 0, 0, S_I, 1, 0, 2);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, S_I, 1, 0, 2);
    // enable div=4 from idle
    cyc(1, 4, 1, 1, 1, S_R, 1, 0, 4);
    run("10011001100", "00010001000", S_R, 1, 4);
    // boundary request div=2 at cnt=3: applied directly
    cyc(1, 2, 1, 1, 1, S_R, 1, 0, 2);
    run("0101", "0101", S_R, 1, 2);
    // div=3 requested mid-period
    cyc(1, 3, 1, 0, 0, S_P, 0, 0, 2);
    run("1", "1", S_R, 1, 3);
    run("10110110", "00100100", S_R, 1, 3);
    // div=5 on boundary
    cyc(1, 5, 1, 1, 1, S_R, 1, 0, 5);
    run("110011100", "000010000", S_R, 1, 5);
    // back to div=4, then div=6 at cnt=1 with valid held through PEND
    cyc(1, 4, 1, 1, 1, S_R, 1, 0, 4);
    run("1", "0", S_R, 1, 4);
    cyc(1, 6, 1, 0, 0, S_P, 0, 0, 4);
    cyc(1, 9, 1, 0, 0, S_P, 0, 0, 4);
    run("1", "1", S_R, 1, 6);
    run("110001", "000001", S_R, 1, 6);
    // invalid divisors while running
    cyc(1, 1, 1, 1, 0, S_R, 1, 1, 6);
    cyc(1, 0, 1, 1, 0, S_R, 1, 1, 6);
    run("0", "0", S_R, 1, 6);
    // switch to div=5 via PEND
    cyc(1, 5, 1, 0, 0, S_P, 0, 0, 6);
    run("0", "0", S_P, 0, 6);
    run("1", "1", S_R, 1, 5);
    run("1", "0", S_R, 1, 5);
    // stop mid-period: period completes, then idle
    cyc(1, 0, 0, 1, 0, S_P, 0, 0, 5);
    run("00", "00", S_P, 0, 5);
    run("000", "000", S_I, 1, 5);
    // stop and invalid enable while idle
    cyc(1, 0, 0, 0, 0, S_I, 1, 0, 5);
    cyc(1, 1, 1, 0, 0, S_I, 1, 1, 5);
    // reset while PEND discards the pending request
    cyc(1, 4, 1, 1, 1, S_R, 1, 0, 4);
    cyc(1, 7, 1, 1, 0, S_P, 0, 0, 4);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, S_I, 1, 0, 2);
    rst = 1'b0;
    run("000000", "000000", S_I, 1, 2);

    // let the monitor drain the last entry, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
